control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It sits directly upstream of the ALU.
- Owns the program counter, the instruction register and a 4-entry 8-bit register file.
- Fetches from an asynchronous program ROM, drives the ALU operand, operation and enable inputs, and writes the ALU result back to the register file.
- Also provides a simple output port and a sticky halt.

---
 rtl/control_unit.sv | 109 ++++++++++
 tb/tb_control_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer owning the PC, IR and a 4x8 register file.
module control_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        alu_operand1,
  output logic [7:0]        alu_operand2,
  output logic [2:0]        alu_operation,
  output logic              alu_enable,
  input  logic [7:0]        alu_result,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              zero
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, FETCH_IMM = 3'd2, EXECUTE = 3'd3, HALT = 3'd4;
  localparam logic [2:0] OP_NOP = 3'b000, OP_LDI = 3'b001, OP_MOV = 3'b010, OP_ADD = 3'b011,
                         OP_SUB = 3'b100, OP_JMP = 3'b101, OP_OUT = 3'b110, OP_HLT = 3'b111;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [3:0][7:0]   regs_q, regs_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              zero_q, zero_d;
  logic [2:0]        op;
  logic [1:0]        rd, rs;
  assign op = ir_q[7:5];
  assign rd = ir_q[3:2];
  assign rs = ir_q[1:0];
  assign mem_addr = pc_q;
  assign alu_operand1 = regs_q[rd];
  assign alu_operand2 = regs_q[rs];
  assign alu_enable = state_q == EXECUTE;
  assign alu_operation = alu_enable ? op : 3'b000;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign halted = state_q == HALT;
  assign zero = zero_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    regs_d = regs_q;
    out_data_d = out_data_q;
    out_valid_d = 1'b0;
    zero_d = zero_q;
    case (state_q)
      FETCH: begin
        ir_d = mem_rdata;
        pc_d = pc_q + ADDR_W'(1);
        state_d = DECODE;
      end
      DECODE: begin
        state_d = FETCH;
        case (op)
          OP_MOV: regs_d[rd] = regs_q[rs];
          OP_OUT: begin
            out_data_d = regs_q[rs];
            out_valid_d = 1'b1;
          end
          OP_LDI, OP_JMP: state_d = FETCH_IMM;
          OP_ADD, OP_SUB: state_d = EXECUTE;
          OP_HLT: state_d = HALT;
          default: state_d = FETCH;
        endcase
      end
      FETCH_IMM: begin
        state_d = FETCH;
        if (op == OP_LDI) begin
          regs_d[rd] = mem_rdata;
          pc_d = pc_q + ADDR_W'(1);
        end else begin
          pc_d = ADDR_W'(mem_rdata);
        end
      end
      EXECUTE: begin
        regs_d[rd] = alu_result;
        zero_d = alu_result == 8'h00;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      ir_q <= 8'h00;
      regs_q <= '0;
      out_data_q <= 8'h00;
      out_valid_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      regs_q <= regs_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed programs with a scoreboard that checks every out_valid pulse against queued expectations.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_rdata, alu_operand1, alu_operand2, alu_result, out_data;
  logic [2:0] alu_operation;
  logic       alu_enable, out_valid, halted, zero;
  logic [7:0] rom [256];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0, pulses = 0, en_cnt = 0;
  logic [2:0] en_op;
  logic       prev_valid = 1'b0;

  control_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_operation(alu_operation),
    .alu_enable(alu_enable), .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid),
    .halted(halted), .zero(zero)
  );

  always #5 clk = ~clk;
  assign mem_rdata = rom[mem_addr];
  assign alu_result = (alu_operation == 3'b011) ? alu_operand1 + alu_operand2 :
                      (alu_operation == 3'b100) ? alu_operand1 - alu_operand2 : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected value on every out_valid pulse and tracks ALU enable activity.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_data: unexpected pulse with %0h", out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL out_data: got %0h expected %0h", out_data, e);
          end
        end
        if (prev_valid) begin
          errors++;
          $display("FAIL out_valid_consecutive: got 1 expected 0");
        end
      end
      if (alu_enable) begin
        en_cnt++;
        en_op = alu_operation;
      end
    end
    prev_valid = out_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start();
    rst = 1'b1;
    pulses = 0;
    en_cnt = 0;
    en_op = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 8'h00;
  endtask

  initial begin
    clear_rom();
    #1;
    chk("reset_mem_addr", mem_addr, 8'h00);
    chk("reset_halted", halted, 0);
    chk("reset_alu_enable", alu_enable, 0);
    chk("reset_alu_operation", alu_operation, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_zero", zero, 0);
    chk("reset_out_data", out_data, 0);

    // LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0; HLT
    rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'h24; rom[3] = 8'h03;
    rom[4] = 8'h61; rom[5] = 8'hC0; rom[6] = 8'hE0;
    start();
    exp_q.push_back(8'h08);
    step(12);
    chk("s1_not_halted_c12", halted, 0);
    step(1);
    chk("s1_halted_c13", halted, 1);
    chk("s1_pc_at_halt", mem_addr, 8'h07);
    step(6);
    chk("s1_halt_sticky", halted, 1);
    chk("s1_pc_frozen", mem_addr, 8'h07);
    chk("s1_pulses", pulses, 1);
    chk("s1_zero", zero, 0);

    // LDI R2,FF; LDI R3,1; ADD R2,R3; OUT R2; HLT
    clear_rom();
    rom[0] = 8'h28; rom[1] = 8'hFF; rom[2] = 8'h2C; rom[3] = 8'h01;
    rom[4] = 8'h6B; rom[5] = 8'hC2; rom[6] = 8'hE0;
    start();
    exp_q.push_back(8'h00);
    step(14);
    chk("s2_zero", zero, 1);
    chk("s2_en_cycles", en_cnt, 1);
    chk("s2_alu_op", en_op, 3'b011);
    chk("s2_pulses", pulses, 1);

    // LDI R0,0; LDI R1,1; SUB R0,R1; OUT R0; HLT
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h00; rom[2] = 8'h24; rom[3] = 8'h01;
    rom[4] = 8'h81; rom[5] = 8'hC0; rom[6] = 8'hE0;
    start();
    exp_q.push_back(8'hFF);
    step(14);
    chk("s3_zero", zero, 0);
    chk("s3_en_cycles", en_cnt, 1);
    chk("s3_alu_op", en_op, 3'b100);
    chk("s3_out_data", out_data, 8'hFF);

    // JMP 10 over a field of HLTs; OUT R0; OUT R0; HLT
    clear_rom();
    rom[0] = 8'hA0; rom[1] = 8'h10;
    for (int i = 2; i < 16; i++) rom[i] = 8'hE0;
    rom[16] = 8'hC0; rom[17] = 8'hC0; rom[18] = 8'hE0;
    start();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    step(3);
    chk("s4_jmp_target", mem_addr, 8'h10);
    chk("s4_not_halted", halted, 0);
    step(6);
    chk("s4_halted", halted, 1);
    chk("s4_pc", mem_addr, 8'h13);
    chk("s4_pulses", pulses, 2);

    // Reset during EXECUTE of ADD R0,R1 with R0=R1=4, then run to completion
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h04; rom[2] = 8'h24; rom[3] = 8'h04;
    rom[4] = 8'h61; rom[5] = 8'hC0; rom[6] = 8'hE0;
    start();
    step(8);
    chk("s5_in_execute", alu_enable, 1);
    chk("s5_operand1", alu_operand1, 8'h04);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_alu_enable", alu_enable, 0);
    chk("s5_rst_pc", mem_addr, 8'h00);
    chk("s5_rst_r0", alu_operand1, 8'h00);
    chk("s5_rst_alu_op", alu_operation, 0);
    start();
    exp_q.push_back(8'h08);
    chk("s5_restart_addr", mem_addr, 8'h00);
    step(13);
    chk("s5_halted", halted, 1);
    chk("s5_pulses", pulses, 1);

    // LDI R2,xx; JMP FF; at FF: LDI R1 with immediate wrapping to address 0
    clear_rom();
    rom[0] = 8'h2A; rom[1] = 8'h00; rom[2] = 8'hA0; rom[3] = 8'hFF; rom[255] = 8'h24;
    start();
    step(6);
    chk("s6_at_ff", mem_addr, 8'hFF);
    step(3);
    chk("s6_pc_wrapped", mem_addr, 8'h01);
    chk("s6_r1_loaded", alu_operand1, 8'h2A);

    step(2);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
